// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI flash target. Decodes READ (0x03), FAST READ (0x0B)
// and READ ID (0x9F), and streams bytes from a byte-wide read port with one cycle of
// latency. The SPI pins are oversampled on the system clock.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int          ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_ID     = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_ID   = 8'h9F;

  logic [1:0]  rst_pipe;
  logic        rst_int_n;
  logic [1:0]  sclk_sync;
  logic [1:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic        sclk_prev;
  logic        sclk_s;
  logic        cs_s;
  logic        mosi_s;
  logic        rise;
  logic        fall;

  logic [2:0]  state;
  logic [2:0]  bit_cnt;
  logic [4:0]  addr_cnt;
  logic [6:0]  cmd_sr;
  logic [22:0] addr_sr;
  logic        is_fast;
  logic [2:0]  out_cnt;
  logic        first_byte;
  logic [7:0]  shift_out;
  logic [7:0]  hold;
  logic [1:0]  load_first_q;
  logic [1:0]  load_hold_q;
  logic [1:0]  id_idx;
  logic [7:0]  next_byte;
  logic [7:0]  byte_src;

  // Reset is asserted asynchronously and released only on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_int_n = rst_pipe[1];

  // Two-flop synchronizers for the SPI pins plus a delayed copy of spi_clk for edge detect
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign sclk_s = sclk_sync[1];
  assign cs_s   = cs_sync[1];
  assign mosi_s = mosi_sync[1];
  assign rise   = sclk_s & ~sclk_prev;
  assign fall   = ~sclk_s & sclk_prev;
  assign busy   = (state != ST_IDLE);

  // Choose the byte that feeds miso: a fresh byte at each byte boundary, else the shifter
  always_comb begin
    next_byte = hold;
    if (state == ST_ID) begin
      case (id_idx)
        2'd1:    next_byte = JEDEC_ID[15:8];
        2'd2:    next_byte = JEDEC_ID[7:0];
        default: next_byte = 8'hFF;
      endcase
    end
    byte_src = shift_out;
    if ((out_cnt == 3'd0) && !first_byte) byte_src = next_byte;
  end

  // Command decoder, address collector and output shifter
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      addr_cnt     <= 5'd0;
      cmd_sr       <= 7'd0;
      addr_sr      <= 23'd0;
      is_fast      <= 1'b0;
      out_cnt      <= 3'd0;
      first_byte   <= 1'b0;
      shift_out    <= 8'd0;
      hold         <= 8'd0;
      load_first_q <= 2'b00;
      load_hold_q  <= 2'b00;
      id_idx       <= 2'd0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
    end else begin
      mem_rd       <= 1'b0;
      load_first_q <= {load_first_q[0], 1'b0};
      load_hold_q  <= {load_hold_q[0], 1'b0};
      if (load_first_q[1]) shift_out <= mem_data;
      if (load_hold_q[1])  hold      <= mem_data;

      if (cs_s) begin
        state        <= ST_IDLE;
        spi_miso_oe  <= 1'b0;
        spi_miso     <= 1'b0;
        bit_cnt      <= 3'd0;
        addr_cnt     <= 5'd0;
        out_cnt      <= 3'd0;
        id_idx       <= 2'd0;
        first_byte   <= 1'b0;
        load_first_q <= 2'b00;
        load_hold_q  <= 2'b00;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_CMD;
            bit_cnt <= 3'd0;
          end
          ST_CMD: begin
            if (rise) begin
              cmd_sr  <= {cmd_sr[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case ({cmd_sr, mosi_s})
                  OP_READ: begin
                    state    <= ST_ADDR;
                    is_fast  <= 1'b0;
                    addr_cnt <= 5'd0;
                  end
                  OP_FAST: begin
                    state    <= ST_ADDR;
                    is_fast  <= 1'b1;
                    addr_cnt <= 5'd0;
                  end
                  OP_ID: begin
                    state       <= ST_ID;
                    spi_miso_oe <= 1'b1;
                    shift_out   <= JEDEC_ID[23:16];
                    first_byte  <= 1'b1;
                    out_cnt     <= 3'd0;
                    id_idx      <= 2'd0;
                  end
                  default: state <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (rise) begin
              addr_sr  <= {addr_sr[21:0], mosi_s};
              addr_cnt <= addr_cnt + 5'd1;
              if (addr_cnt == 5'd23) begin
                mem_addr        <= ADDR_W'({addr_sr, mosi_s});
                mem_rd          <= 1'b1;
                load_first_q[0] <= 1'b1;
                first_byte      <= 1'b1;
                out_cnt         <= 3'd0;
                bit_cnt         <= 3'd0;
                spi_miso_oe     <= 1'b1;
                state           <= is_fast ? ST_DUMMY : ST_DATA;
              end
            end
          end
          ST_DUMMY: begin
            if (fall) spi_miso <= 1'b0;
            if (rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_DATA;
            end
          end
          ST_DATA, ST_ID: begin
            if (fall) begin
              spi_miso   <= byte_src[7];
              shift_out  <= {byte_src[6:0], 1'b0};
              out_cnt    <= out_cnt + 3'd1;
              first_byte <= 1'b0;
              if (out_cnt == 3'd7) begin
                if (state == ST_DATA) begin
                  mem_addr       <= mem_addr + ADDR_W'(1);
                  mem_rd         <= 1'b1;
                  load_hold_q[0] <= 1'b1;
                end else if (id_idx != 2'd3) begin
                  id_idx <= id_idx + 2'd1;
                end
              end
            end
          end
          ST_IGNORE: begin
            spi_miso_oe <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: drives mode-0 SPI transactions into spi_flash_responder and
// compares returned bytes against a memory image and the JEDEC id.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          half = 4;
  logic [7:0]  mem_img [256];
  logic [23:0] rd_log [$];
  logic [7:0]  rx_buf [128];
  logic [7:0]  dummy_rx;
  logic        dummy_oe;
  logic        oe_all;
  logic        oe_any;
  logic [23:0] jedec = 24'hEF4016;

  spi_flash_responder #(
    .JEDEC_ID(24'hEF4016),
    .ADDR_W  (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [23:0] a);
    return mem_img[a[7:0]] ^ a[15:8] ^ a[23:16];
  endfunction

  // Synchronous read port with one cycle of latency; also records every read address
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_model(mem_addr);
      rd_log.push_back(mem_addr);
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (half) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      oe_all = oe_all & spi_miso_oe;
      oe_any = oe_any | spi_miso_oe;
      spi_clk = 1'b1;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    spi_clk  = 1'b0;
    spi_cs_n = 1'b0;
    oe_all   = 1'b1;
    oe_any   = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic cs_end(output int lat);
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        lat = c;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_read(input logic [7:0] op, input logic [23:0] addr, input int nbytes,
                          output int lat);
    logic [7:0] r;
    cs_begin();
    spi_bits(op, 8, r);
    spi_bits(addr[23:16], 8, r);
    spi_bits(addr[15:8], 8, r);
    spi_bits(addr[7:0], 8, r);
    if (op == 8'h0B) begin
      oe_all = 1'b1;
      spi_bits(8'($urandom), 8, dummy_rx);
      dummy_oe = oe_all;
    end
    oe_all = 1'b1;
    for (int k = 0; k < nbytes; k++) spi_bits(8'($urandom), 8, rx_buf[k]);
    cs_end(lat);
  endtask

  task automatic run_id(input int nbytes, output int lat);
    logic [7:0] r;
    cs_begin();
    spi_bits(8'h9F, 8, r);
    oe_all = 1'b1;
    for (int k = 0; k < nbytes; k++) spi_bits(8'($urandom), 8, rx_buf[k]);
    cs_end(lat);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_miso, spi_miso_oe, mem_rd, busy} !== 4'b0000 || mem_addr !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got miso/oe/rd/busy=%b addr=%h exp 0000 addr 000000",
               {spi_miso, spi_miso_oe, mem_rd, busy}, mem_addr);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_read_basic();
    logic [7:0] exp_b [4];
    int lat;
    exp_b = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    for (int i = 0; i < 256; i++) mem_img[i] = 8'(i) ^ 8'hA5;
    half = 4;
    rd_log.delete();
    run_read(8'h03, 24'h000010, 4, lat);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_buf[k] !== exp_b[k]) begin
        failures++;
        $display("[TB] FAIL read_byte%0d got=%h exp=%h", k, rx_buf[k], exp_b[k]);
      end
    end
    checks++;
    if (rd_log.size() != 5) begin
      failures++;
      $display("[TB] FAIL read_rd_count got=%0d exp=5", rd_log.size());
    end
    checks++;
    if (oe_all !== 1'b1) begin
      failures++;
      $display("[TB] FAIL read_oe got=%b exp=1", oe_all);
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("[TB] FAIL busy_latency got=%0d exp=3", lat);
    end
  endtask

  task automatic test_fast();
    int lat;
    randomize_mem();
    half = 8;
    rd_log.delete();
    run_read(8'h0B, 24'h000100, 2, lat);
    checks++;
    if (dummy_rx !== 8'h00 || dummy_oe !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fast_dummy got rx=%h oe=%b exp rx=00 oe=1", dummy_rx, dummy_oe);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rx_buf[k] !== mem_model(24'h000100 + 24'(k))) begin
        failures++;
        $display("[TB] FAIL fast_byte%0d got=%h exp=%h", k, rx_buf[k],
                 mem_model(24'h000100 + 24'(k)));
      end
    end
    checks++;
    if (rd_log.size() != 3) begin
      failures++;
      $display("[TB] FAIL fast_rd_count got=%0d exp=3", rd_log.size());
    end
  endtask

  task automatic test_id();
    logic [7:0] exp_b [4];
    int lat;
    exp_b = '{8'hEF, 8'h40, 8'h16, 8'hFF};
    half = 4;
    rd_log.delete();
    run_id(4, lat);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_buf[k] !== exp_b[k]) begin
        failures++;
        $display("[TB] FAIL id_byte%0d got=%h exp=%h", k, rx_buf[k], exp_b[k]);
      end
    end
    checks++;
    if (rd_log.size() != 0 || oe_all !== 1'b1) begin
      failures++;
      $display("[TB] FAIL id_no_read got rd=%0d oe=%b exp rd=0 oe=1", rd_log.size(), oe_all);
    end
  endtask

  task automatic test_wrap();
    int lat;
    randomize_mem();
    half = 4;
    rd_log.delete();
    run_read(8'h03, 24'hFFFFFF, 2, lat);
    checks++;
    if (rd_log.size() != 3) begin
      failures++;
      $display("[TB] FAIL wrap_rd_count got=%0d exp=3", rd_log.size());
    end else begin
      checks++;
      if (rd_log[0] !== 24'hFFFFFF || rd_log[1] !== 24'h000000) begin
        failures++;
        $display("[TB] FAIL wrap_addr got=%h,%h exp=ffffff,000000", rd_log[0], rd_log[1]);
      end
    end
    checks++;
    if (rx_buf[0] !== mem_model(24'hFFFFFF) || rx_buf[1] !== mem_model(24'h000000)) begin
      failures++;
      $display("[TB] FAIL wrap_data got=%h,%h exp=%h,%h", rx_buf[0], rx_buf[1],
               mem_model(24'hFFFFFF), mem_model(24'h000000));
    end
  endtask

  task automatic test_ignore();
    logic [7:0] r;
    int lat;
    randomize_mem();
    half = 4;
    cs_begin();
    spi_bits(8'h05, 8, r);
    spi_bits(8'($urandom), 8, r);
    spi_bits(8'($urandom), 8, r);
    cs_end(lat);
    checks++;
    if (oe_any !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_oe got=%b exp=0", oe_any);
    end
    run_read(8'h03, 24'h000000, 1, lat);
    checks++;
    if (rx_buf[0] !== mem_model(24'h000000)) begin
      failures++;
      $display("[TB] FAIL after_ignore_byte got=%h exp=%h", rx_buf[0], mem_model(24'h000000));
    end
  endtask

  task automatic test_abort_reset();
    logic [7:0] r;
    logic [23:0] a;
    int lat;
    randomize_mem();
    half = 4;
    rd_log.delete();
    cs_begin();
    spi_bits(8'h03, 8, r);
    spi_bits(8'h12, 8, r);
    spi_bits(8'h34, 5, r);
    cs_end(lat);
    checks++;
    if (lat != 3 || rd_log.size() != 0) begin
      failures++;
      $display("[TB] FAIL abort_addr got lat=%0d rd=%0d exp lat=3 rd=0", lat, rd_log.size());
    end
    a = 24'($urandom);
    cs_begin();
    spi_bits(8'h03, 8, r);
    spi_bits(a[23:16], 8, r);
    spi_bits(a[15:8], 8, r);
    spi_bits(a[7:0], 8, r);
    spi_bits(8'h00, 8, r);
    spi_bits(8'h00, 3, r);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_miso, spi_miso_oe, mem_rd, busy} !== 4'b0000 || mem_addr !== 24'h0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got miso/oe/rd/busy=%b addr=%h exp 0000 addr 000000",
               {spi_miso, spi_miso_oe, mem_rd, busy}, mem_addr);
    end
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    a = 24'($urandom);
    run_read(8'h03, a, 3, lat);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx_buf[k] !== mem_model(a + 24'(k))) begin
        failures++;
        $display("[TB] FAIL post_reset_byte%0d got=%h exp=%h", k, rx_buf[k], mem_model(a + 24'(k)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    logic [7:0]  op;
    logic [7:0]  e;
    int          len;
    int          sel;
    int          lat;
    randomize_mem();
    for (int t = 0; t < 12; t++) begin
      half = ($urandom_range(0, 1) == 1) ? 8 : 4;
      sel  = $urandom_range(0, 2);
      len  = $urandom_range(1, 6);
      a    = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 3));
      rd_log.delete();
      if (sel == 2) begin
        run_id(len, lat);
        for (int k = 0; k < len; k++) begin
          e = (k < 3) ? 8'(jedec >> (16 - 8 * k)) : 8'hFF;
          checks++;
          if (rx_buf[k] !== e) begin
            failures++;
            $display("[TB] FAIL b2b%0d_id_byte%0d got=%h exp=%h", t, k, rx_buf[k], e);
          end
        end
      end else begin
        op = (sel == 1) ? 8'h0B : 8'h03;
        run_read(op, a, len, lat);
        for (int k = 0; k < len; k++) begin
          checks++;
          if (rx_buf[k] !== mem_model(a + 24'(k))) begin
            failures++;
            $display("[TB] FAIL b2b%0d_byte%0d got=%h exp=%h", t, k, rx_buf[k],
                     mem_model(a + 24'(k)));
          end
        end
        checks++;
        if (rd_log.size() != len + 1) begin
          failures++;
          $display("[TB] FAIL b2b%0d_rd_count got=%0d exp=%0d", t, rd_log.size(), len + 1);
        end else if (rd_log[len] !== a + 24'(len)) begin
          failures++;
          $display("[TB] FAIL b2b%0d_prefetch_addr got=%h exp=%h", t, rd_log[len], a + 24'(len));
        end
      end
      checks++;
      if (lat != 3) begin
        failures++;
        $display("[TB] FAIL b2b%0d_busy_latency got=%0d exp=3", t, lat);
      end
    end
  endtask

  task automatic test_stream64();
    logic [23:0] a;
    int          lat;
    int          bad;
    for (int s = 0; s < 2; s++) begin
      randomize_mem();
      half = (s == 0) ? 4 : 8;
      a = 24'($urandom);
      run_read(8'h03, a, 64, lat);
      bad = 0;
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (rx_buf[k] !== mem_model(a + 24'(k))) begin
          failures++;
          bad++;
          if (bad <= 4)
            $display("[TB] FAIL stream%0d_byte%0d got=%h exp=%h", half, k, rx_buf[k],
                     mem_model(a + 24'(k)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_fast();
    test_id();
    test_wrap();
    test_ignore();
    test_abort_reset();
    test_back_to_back();
    test_stream64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
